unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the pipelined CPU's fetch stage (PCF → IM_RD) and memory stage (ALUOutM/WriteDataM/MemWriteM → DM_RD).
- Owns the memory sequencing FSM, arbitrates between the two requesters with data-side priority plus anti-starvation, and generates fetch/memory stall signals for the hazard logic.
- Sits between the CPU core and the unified memory model at SoC/testbench top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from MEM_EN to valid MEM_RD. Legal range 1..4; out-of-range is a compile-time error.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous reset, active-low (0 = reset).
- I_REQ  in  1  fetch request; held high until I_VALID.
- I_ADDR  in  ADDR_W  fetch address (PCF).
- I_RDATA  out  DATA_W  fetched instruction.
- I_VALID  out  1  one-cycle completion pulse for fetch.
- D_REQ  in  1  data request; held high until D_VALID.
- D_WE  in  1  1 = write, 0 = read.
- D_ADDR  in  ADDR_W  data address (ALUOutM).
- D_WDATA  in  DATA_W  write data (WriteDataM).
- D_RDATA  out  DATA_W  load data.
- D_VALID  out  1  one-cycle completion pulse for data.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_RD  in  DATA_W  memory read data, valid MEM_LAT cycles after MEM_EN.
- STALL_F  out  1  I_REQ & ~I_VALID (combinational).
- STALL_M  out  1  D_REQ & ~D_VALID (combinational).

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, wait counter=0, last_grant=I.
  - MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, I_RDATA, D_RDATA, I_VALID, D_VALID all 0.
  - Reset mid-transaction aborts the transaction; MEM_EN drops immediately and no VALID is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples I_REQ and D_REQ at each posedge.
  - Grant selection:
    - If both are requested: D wins, unless last_grant=D and the previous D grant came back-to-back with I pending. In that case I wins, so D is never granted twice consecutively while I is waiting.
    - Otherwise, the single requester wins.
  - On a grant: capture addr/we/wdata into registers, set last_grant, go to ISSUE.
  - Fetch requests are always treated as reads.
- ISSUE (exactly 1 cycle):
  - MEM_EN=1; MEM_WE = captured we; MEM_ADDR and MEM_WDATA from the captured registers.
  - Next state: write → DONE; read → WAIT with counter=MEM_LAT.
- WAIT:
  - MEM_EN=0; counter decrements each cycle.
  - In the cycle where counter=1, MEM_RD is captured into the granted requester's RDATA register; next state DONE.
  - The non-granted RDATA register is unchanged.
- DONE (1 cycle):
  - Granted VALID=1; next state IDLE.
  - RDATA holds its value until that requester's next read completes.
- Cycle latency, with c0 = the IDLE sample cycle:
  - Read: MEM_EN in c1, MEM_RD sampled at the end of c(1+MEM_LAT), VALID in c(2+MEM_LAT).
  - Write: MEM_EN in c1, VALID in c2.
- Handshake rules:
  - The requester keeps REQ and its address/data stable until it sees VALID, then may drop or change REQ at the next edge.
  - The arbiter never regrants in the DONE cycle, so a stale REQ seen in DONE is ignored.
  - REQ dropped before VALID is a protocol violation. The transaction still completes and its VALID pulse is still produced.
  - The unused requester's inputs are don't-care.
- Outputs:
  - At most one transaction is in flight; MEM_EN is never high on two consecutive cycles.
  - I_VALID and D_VALID are never high in the same cycle.
  - Address wrap and alignment are not checked; addresses pass through unmodified.

Decomposition:
- Shared package (cpu_mem_pkg): FSM state enum (IDLE, ISSUE, WAIT, DONE), grant enum (GNT_I, GNT_D), MEM_LAT legal-range constants.
- One natural sub-module: mem_lat_counter (load MEM_LAT, decrement, last-cycle flag).
- Arbitration and capture logic stay in the top module.

Test Plan:
- Reset: RST=0 mid-read at MEM_LAT=2 → MEM_EN=0 within the same cycle, no I_VALID or D_VALID afterwards, state IDLE after RST returns to 1.
- Fetch only, MEM_LAT=1:
  - Stimulus: I_REQ=1, I_ADDR=0x0000_0004 in c0; memory returns 0x2002_0005.
  - Expected: MEM_EN=1 in c1 with MEM_ADDR=0x4; I_VALID=1 in c3 with I_RDATA=0x2002_0005; STALL_F=1 in c0–c2.
- Data write:
  - Stimulus: D_REQ=1, D_WE=1, D_ADDR=0x10, D_WDATA=0xDEAD_BEEF.
  - Expected: in c1 MEM_EN=1, MEM_WE=1, MEM_ADDR=0x10, MEM_WDATA=0xDEAD_BEEF; D_VALID in c2; I_RDATA unchanged.
- Simultaneous requests:
  - Stimulus: I_REQ and D_REQ (read, memory returns 0x0000_0002) both high in the same cycle.
  - Expected: D served first (D_VALID carries 0x2), then I served; I_VALID is never coincident with D_VALID.
- Anti-starvation: I_REQ held high, D_REQ re-asserted immediately after each D_VALID → grant order D, I, D, I.
- MEM_LAT=4 read: VALID exactly 6 cycles after the sample cycle; MEM_RD driven with garbage in WAIT cycles 1–3 is not captured; only the value present at counter=1 appears in RDATA.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified memory arbiter.
// The package holds the sequencing states, the grant owner and the legal MEM_LAT range.
package cpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency down-counter. It loads MEM_LAT, counts down to zero, and flags the
// cycle in which the read data from memory is valid.
module mem_lat_counter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Lets the fetch stage and the memory stage share one single-port, fixed-latency memory.
// The data side has priority, with an anti-starvation rule for fetch; the module also drives the stall outputs.
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_RDATA,
  output logic              I_VALID,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_VALID,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RD,
  output logic              STALL_F,
  output logic              STALL_M
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_range
    $error("unified_mem_arbiter: MEM_LAT must be within 1..4");
  end

  state_t            state, state_nxt;
  gnt_t              gnt;
  logic              d_over_i;
  logic              grant, pick_d, cnt_load, cnt_last;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;

  assign grant  = (state == IDLE) && (I_REQ || D_REQ);
  // d_over_i records that the last D grant went ahead of a waiting fetch; that fetch goes next
  assign pick_d = D_REQ && !(I_REQ && (gnt == GNT_D) && d_over_i);

  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk   (CLK),
    .rst_n (RST),
    .load  (cnt_load),
    .last  (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    case (state)
      IDLE:  if (grant) state_nxt = ISSUE;
      ISSUE: begin
        if (we_q) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
          cnt_load  = 1'b1;
        end
      end
      WAIT:    if (cnt_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      gnt       <= GNT_I;
      d_over_i  <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt      <= pick_d ? GNT_D : GNT_I;
        d_over_i <= pick_d && I_REQ;
        addr_q   <= pick_d ? D_ADDR : I_ADDR;
        we_q     <= pick_d && D_WE;
        wdata_q  <= pick_d ? D_WDATA : '0;
      end
      if (state == WAIT && cnt_last) begin
        if (gnt == GNT_I) i_rdata_q <= MEM_RD;
        else              d_rdata_q <= MEM_RD;
      end
    end
  end

  assign MEM_EN    = (state == ISSUE);
  assign MEM_WE    = (state == ISSUE) && we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign I_RDATA   = i_rdata_q;
  assign D_RDATA   = d_rdata_q;
  assign I_VALID   = (state == DONE) && (gnt == GNT_I);
  assign D_VALID   = (state == DONE) && (gnt == GNT_D);
  assign STALL_F   = I_REQ && !I_VALID;
  assign STALL_M   = D_REQ && !D_VALID;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter. It builds three instances with MEM_LAT set to 1, 2 and 4.
// It uses directed vectors and sequences, then random traffic checked against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int NI = 3;

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] def_word(input logic [6:0] idx);
    return {9'h15A, idx, ~{9'h0B3, idx}};
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req [NI];
  logic [31:0] i_addr [NI];
  logic [31:0] i_rdata [NI];
  logic        i_valid [NI];
  logic        d_req [NI];
  logic        d_we [NI];
  logic [31:0] d_addr [NI];
  logic [31:0] d_wdata [NI];
  logic [31:0] d_rdata [NI];
  logic        d_valid [NI];
  logic        mem_en [NI];
  logic        mem_we [NI];
  logic [31:0] mem_addr [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rd [NI];
  logic        stall_f [NI];
  logic        stall_m [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(lat_of(g))) dut (
      .CLK(clk), .RST(rst_n),
      .I_REQ(i_req[g]), .I_ADDR(i_addr[g]), .I_RDATA(i_rdata[g]), .I_VALID(i_valid[g]),
      .D_REQ(d_req[g]), .D_WE(d_we[g]), .D_ADDR(d_addr[g]), .D_WDATA(d_wdata[g]),
      .D_RDATA(d_rdata[g]), .D_VALID(d_valid[g]),
      .MEM_EN(mem_en[g]), .MEM_WE(mem_we[g]), .MEM_ADDR(mem_addr[g]), .MEM_WDATA(mem_wdata[g]),
      .MEM_RD(mem_rd[g]), .STALL_F(stall_f[g]), .STALL_M(stall_m[g])
    );
  end

  // Memory model: read data is valid exactly MEM_LAT cycles after MEM_EN; at all other times it is random junk
  logic [31:0] rmem [NI][128];
  logic        rwr [NI][128];
  int          pend_cnt [NI];
  logic [6:0]  pend_idx [NI];
  logic [31:0] junk [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      junk[k] <= $urandom;
      if (!rst_n) begin
        pend_cnt[k] <= 0;
        for (int j = 0; j < 128; j++) rwr[k][j] <= 1'b0;
      end else if (mem_en[k]) begin
        pend_idx[k] <= mem_addr[k][8:2];
        pend_cnt[k] <= mem_we[k] ? 0 : int'(lat_of(k));
        if (mem_we[k]) begin
          rmem[k][mem_addr[k][8:2]] <= mem_wdata[k];
          rwr[k][mem_addr[k][8:2]]  <= 1'b1;
        end
      end else if (pend_cnt[k] != 0) begin
        pend_cnt[k] <= pend_cnt[k] - 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      mem_rd[k] = junk[k];
      if (pend_cnt[k] == 1)
        mem_rd[k] = rwr[k][pend_idx[k]] ? rmem[k][pend_idx[k]] : def_word(pend_idx[k]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_i(input int k, input logic req, input logic [31:0] addr);
    i_req[k]  = req;
    i_addr[k] = addr;
  endtask

  task automatic set_d(input int k, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    d_req[k]   = req;
    d_we[k]    = we;
    d_addr[k]  = addr;
    d_wdata[k] = wdata;
  endtask

  typedef struct {
    logic ireq; logic [31:0] ia;
    logic dreq; logic dwe; logic [31:0] da; logic [31:0] dw;
    logic en; logic we; logic [31:0] ma; logic [31:0] mw;
    logic iv; logic dv; logic [31:0] ird; logic [31:0] drd;
    logic sf; logic sm;
  } vec_t;

  function automatic vec_t v(logic ireq, logic [31:0] ia, logic dreq, logic dwe,
                             logic [31:0] da, logic [31:0] dw, logic en, logic we,
                             logic [31:0] ma, logic [31:0] mw, logic iv, logic dv,
                             logic [31:0] ird, logic [31:0] drd, logic sf, logic sm);
    vec_t r;
    r.ireq = ireq; r.ia = ia; r.dreq = dreq; r.dwe = dwe; r.da = da; r.dw = dw;
    r.en = en; r.we = we; r.ma = ma; r.mw = mw; r.iv = iv; r.dv = dv;
    r.ird = ird; r.drd = drd; r.sf = sf; r.sm = sm;
    return r;
  endfunction

  // Random traffic on instance k, checked against a transaction-level model of grant order, latency and data
  task automatic run_random(input int k, input int ncyc);
    logic [31:0] ref_mem [128];
    bit          ref_wr [128];
    int          idle_from = 0, issue_cyc = -1, valid_cyc = -1;
    bit          pend = 0, pend_d = 0, pend_rd = 0, i_skipped = 0, ip = 0, dp = 0, take_d;
    logic [31:0] pend_data = '0, pend_addr = '0, exp_ird = '0, exp_drd = '0, a;
    logic [6:0]  ix;
    for (int j = 0; j < 128; j++) ref_wr[j] = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      chk1("rnd_en", mem_en[k], pend && n == issue_cyc);
      if (pend && n == issue_cyc) chk("rnd_maddr", mem_addr[k], pend_addr);
      chk1("rnd_iv", i_valid[k], pend && n == valid_cyc && !pend_d);
      chk1("rnd_dv", d_valid[k], pend && n == valid_cyc && pend_d);
      if (pend && n == valid_cyc) begin
        if (pend_rd && pend_d) exp_drd = pend_data;
        if (pend_rd && !pend_d) exp_ird = pend_data;
        pend = 0;
        idle_from = n + 1;
      end
      chk("rnd_irdata", i_rdata[k], exp_ird);
      chk("rnd_drdata", d_rdata[k], exp_drd);
      if (i_valid[k]) ip = 0;
      if (d_valid[k]) dp = 0;
      if (!ip && n < ncyc - 20 && $urandom_range(0, 2) == 0) begin
        ip = 1;
        set_i(k, 1'b1, 32'h100 + 32'($urandom_range(0, 63)) * 4);
      end
      if (!ip) i_req[k] = 1'b0;
      if (!dp && n < ncyc - 20 && $urandom_range(0, 2) == 0) begin
        dp = 1;
        set_d(k, 1'b1, 1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 63)) * 4, $urandom);
      end
      if (!dp) d_req[k] = 1'b0;
      #1;
      chk1("rnd_stall_f", stall_f[k], i_req[k] && !i_valid[k]);
      chk1("rnd_stall_m", stall_m[k], d_req[k] && !d_valid[k]);
      if (!pend && n >= idle_from && (i_req[k] || d_req[k])) begin
        take_d    = d_req[k] && !(i_req[k] && i_skipped);
        i_skipped = take_d && i_req[k];
        a         = take_d ? d_addr[k] : i_addr[k];
        ix        = a[8:2];
        pend      = 1;
        pend_d    = take_d;
        pend_addr = a;
        issue_cyc = n + 1;
        if (take_d && d_we[k]) begin
          pend_rd     = 0;
          ref_mem[ix] = d_wdata[k];
          ref_wr[ix]  = 1;
          valid_cyc   = n + 2;
        end else begin
          pend_rd   = 1;
          pend_data = ref_wr[ix] ? ref_mem[ix] : def_word(ix);
          valid_cyc = n + 2 + int'(lat_of(k));
        end
      end
    end
    chk1("rnd_drained", pend, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[$];
    int   ord[4];
    int   got;
    logic [31:0] X20, DB;
    X20 = 32'h2002_0005;
    DB  = 32'hDEAD_BEEF;
    for (int k = 0; k < NI; k++) begin
      set_i(k, 1'b0, '0);
      set_d(k, 1'b0, 1'b0, '0, '0);
    end
    rst_n = 1'b0;
    #1;
    chk1("reset_en", mem_en[0], 1'b0);
    chk1("reset_iv", i_valid[2], 1'b0);
    chk1("reset_dv", d_valid[1], 1'b0);
    chk("reset_irdata", i_rdata[0], '0);
    chk("reset_maddr", mem_addr[2], '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Instance 0 (MEM_LAT=1): write, fetch, write, then a fetch and a load requested together
    vt.push_back(v(0,0, 1,1,32'h4,X20,  0,0,0,0,          0,0, 0,0,   0,1));
    vt.push_back(v(0,0, 1,1,32'h4,X20,  1,1,32'h4,X20,    0,0, 0,0,   0,1));
    vt.push_back(v(0,0, 1,1,32'h4,X20,  0,0,0,0,          0,1, 0,0,   0,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    0,0,0,0,          0,0, 0,0,   1,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    1,0,32'h4,0,      0,0, 0,0,   1,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    0,0,0,0,          0,0, 0,0,   1,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    0,0,0,0,          1,0, X20,0, 0,0));
    vt.push_back(v(0,0, 1,1,32'h10,DB,  0,0,0,0,          0,0, X20,0, 0,1));
    vt.push_back(v(0,0, 1,1,32'h10,DB,  1,1,32'h10,DB,    0,0, X20,0, 0,1));
    vt.push_back(v(0,0, 1,1,32'h10,DB,  0,0,0,0,          0,1, X20,0, 0,0));
    vt.push_back(v(0,0, 1,1,32'h8,32'h2, 0,0,0,0,         0,0, X20,0, 0,1));
    vt.push_back(v(0,0, 1,1,32'h8,32'h2, 1,1,32'h8,32'h2, 0,0, X20,0, 0,1));
    vt.push_back(v(0,0, 1,1,32'h8,32'h2, 0,0,0,0,         0,1, X20,0, 0,0));
    vt.push_back(v(1,32'h4, 1,0,32'h8,0, 0,0,0,0,         0,0, X20,0, 1,1));
    vt.push_back(v(1,32'h4, 1,0,32'h8,0, 1,0,32'h8,0,     0,0, X20,0, 1,1));
    vt.push_back(v(1,32'h4, 1,0,32'h8,0, 0,0,0,0,         0,0, X20,0, 1,1));
    vt.push_back(v(1,32'h4, 1,0,32'h8,0, 0,0,0,0,         0,1, X20,2, 1,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    0,0,0,0,          0,0, X20,2, 1,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    1,0,32'h4,0,      0,0, X20,2, 1,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    0,0,0,0,          0,0, X20,2, 1,0));
    vt.push_back(v(1,32'h4, 0,0,0,0,    0,0,0,0,          1,0, X20,2, 0,0));
    vt.push_back(v(0,0, 0,0,0,0,        0,0,0,0,          0,0, X20,2, 0,0));
    for (int r = 0; r < vt.size(); r++) begin
      @(negedge clk);
      set_i(0, vt[r].ireq, vt[r].ia);
      set_d(0, vt[r].dreq, vt[r].dwe, vt[r].da, vt[r].dw);
      #1;
      chk1($sformatf("tbl%0d_en", r), mem_en[0], vt[r].en);
      if (vt[r].en) begin
        chk1($sformatf("tbl%0d_we", r), mem_we[0], vt[r].we);
        chk($sformatf("tbl%0d_maddr", r), mem_addr[0], vt[r].ma);
        if (vt[r].we) chk($sformatf("tbl%0d_mwdata", r), mem_wdata[0], vt[r].mw);
      end
      chk1($sformatf("tbl%0d_iv", r), i_valid[0], vt[r].iv);
      chk1($sformatf("tbl%0d_dv", r), d_valid[0], vt[r].dv);
      chk($sformatf("tbl%0d_irdata", r), i_rdata[0], vt[r].ird);
      chk($sformatf("tbl%0d_drdata", r), d_rdata[0], vt[r].drd);
      chk1($sformatf("tbl%0d_stall_f", r), stall_f[0], vt[r].sf);
      chk1($sformatf("tbl%0d_stall_m", r), stall_m[0], vt[r].sm);
    end

    // Anti-starvation on instance 1: both sides request continuously
    @(negedge clk);
    set_i(1, 1'b1, 32'h40);
    set_d(1, 1'b1, 1'b0, 32'h44, '0);
    got = 0;
    for (int n = 0; n < 80 && got < 4; n++) begin
      @(negedge clk);
      chk1("starve_excl", i_valid[1] && d_valid[1], 1'b0);
      if (d_valid[1]) begin ord[got] = 1; got++; end
      else if (i_valid[1]) begin ord[got] = 2; got++; end
    end
    set_i(1, 1'b0, '0);
    set_d(1, 1'b0, 1'b0, '0, '0);
    chk("starve_count", got, 4);
    for (int j = 0; j < got && j < 4; j++)
      chk($sformatf("starve_order%0d", j), ord[j], (j % 2 == 0) ? 1 : 2);

    // A reset during a read at MEM_LAT=2 aborts the read
    repeat (2) @(negedge clk);
    set_d(1, 1'b1, 1'b0, 32'h48, '0);
    @(negedge clk);
    #1 chk1("rst_issue_en", mem_en[1], 1'b1);
    rst_n = 1'b0;
    #1 chk1("rst_en_drop", mem_en[1], 1'b0);
    chk("rst_drdata", d_rdata[1], '0);
    set_d(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk1("rst_no_dv", d_valid[1], 1'b0);
      chk1("rst_no_iv", i_valid[1], 1'b0);
      chk1("rst_no_en", mem_en[1], 1'b0);
    end
    set_d(1, 1'b1, 1'b1, 32'h4C, 32'h5);
    @(negedge clk);
    chk1("rst_idle_en", mem_en[1], 1'b1);
    @(negedge clk);
    chk1("rst_idle_dv", d_valid[1], 1'b1);
    set_d(1, 1'b0, 1'b0, '0, '0);

    // MEM_LAT=4 read: only the word present when the counter reaches 1 is captured
    @(negedge clk);
    set_d(2, 1'b1, 1'b0, 32'h80, '0);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      chk1($sformatf("lat4_en_c%0d", n), mem_en[2], n == 1);
      chk1($sformatf("lat4_dv_c%0d", n), d_valid[2], n == 6);
      if (n == 5) chk("lat4_drd_before", d_rdata[2], '0);
      if (n == 6) begin
        chk("lat4_drd", d_rdata[2], def_word(7'd32));
        set_d(2, 1'b0, 1'b0, '0, '0);
      end
    end

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < NI; k++) run_random(k, 250);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
